// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer around a single 1-bit full-adder cell.
// Ports: clk, rst (async high); in_valid/in_ready + op_a/op_b/op_sub request;
// out_valid/out_ready + sum/carry_out/overflow registered result.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic               w_s;
    logic               w_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    fulladder u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .c    (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_next = {w_s, r_res_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (in_valid)  w_next = S_RUN;
            S_RUN:  if (w_last)    w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted on load and the +1 enters
    // as the initial carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sr  <= op_a;
                        r_b_sr  <= op_sub ? ~op_b : op_b;
                        r_carry <= op_sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next;
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Result registers change only here, so they hold
                    // through DONE and after the handshake.
                    if (w_last) begin
                        r_sum  <= w_res_next;
                        r_cout <= w_cout;
                        r_ovf  <= r_carry ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and model-checked bench for serial_add_ctrl (WIDTH=8).
// Single check task; summary line at end.

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int n_chk;
    int n_fail;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one request for one edge.
    task automatic issue(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic s);
        int k;
        k = 0;
        while (!in_ready && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        op_sub   = $urandom;
    endtask

    // Counts edges after accept until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_res(input string tag,
                             input logic [W-1:0] es,
                             input logic ec,
                             input logic eo);
        chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        chk({tag, "_co"}, {31'd0, carry_out}, {31'd0, ec});
        chk({tag, "_ov"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    task automatic handshake(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic s,
                          input logic [W-1:0] es,
                          input logic ec,
                          input logic eo);
        int lat;
        issue(a, b, s);
        wait_done(lat);
        check_res(tag, es, ec, eo);
        handshake(0);
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic s);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         ov;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full};
    endfunction

    initial begin
        int lat;
        logic [W+1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_res("rst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: accept edge E, out_valid first seen after edge E+8,
        // i.e. in the 9th cycle counting from the accept edge.
        issue(8'h5A, 8'h3C, 1'b0);
        chk("add_busy", {31'd0, in_ready}, 32'd0);
        wait_done(lat);
        chk("add_latency", lat, W);
        check_res("add", 8'h96, 1'b0, 1'b1);
        handshake(0);
        chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
        chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check_res("add_hold", 8'h96, 1'b0, 1'b1);

        run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op("sub1", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub2", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("sub3", 8'h20, 8'h20, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("add2", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // Backpressure with stray requests during DONE.
        issue(8'h12, 8'h34, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op_a     = 8'hA0 + 8'(i);
            op_b     = 8'h0F;
            op_sub   = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_res("bp", 8'h46, 1'b0, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release", {31'd0, in_ready}, 32'd1);
        run_op("bp_next", 8'hC8, 8'h64, 1'b1, 8'h64, 1'b1, 1'b1);

        // Asynchronous reset while cnt==3.
        issue(8'h33, 8'h44, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_sum", {24'd0, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("arst_next", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Randomised operands, gaps and stalls against the model.
        for (int t = 0; t < 200; t++) begin
            ra = $urandom;
            rb = $urandom;
            rs = $urandom;
            m  = model(ra, rb, rs);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            issue(ra, rb, rs);
            wait_done(lat);
            chk("rnd_latency", lat, W);
            check_res("rnd", m[W-1:0], m[W], m[W+1]);
            handshake($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
